dm_access_ctrl: RTL

- Sequences MEM-stage data-memory accesses onto a single-outstanding req/gnt/rvalid bus toward the AXI bridge.
- Drives the pipeline-wide stall consumed by IF_ID, ID_EXE, EXE_MEM and MEM_WB while an access is in flight.
- Returns load data on dm_data, which feeds the DM_data input of the MEM/WB pipeline register.
- Exactly one access is in flight at a time; there is no queueing.

---
 rtl/dm_access_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access sequencer: one outstanding req/gnt/rvalid access
// toward the AXI bridge, with pipeline stall generation and load-data capture.
module dm_access_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_re,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wstrb,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic                bus_gnt,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_err,
    output logic                stall,
    output logic [DATA_W-1:0]   dm_data,
    output logic                access_err
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_e;

    state_e              state_q;
    logic                req_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // access_err is only ever set on the edge into DONE, so it lasts one cycle
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_re || mem_we) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        we_q    <= mem_we;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        req_q <= 1'b0;
                        if (bus_rvalid) begin
                            if (!we_q) begin
                                rdata_q <= bus_rdata;
                            end
                            err_q   <= bus_err;
                            state_q <= DONE;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        if (!we_q) begin
                            rdata_q <= bus_rdata;
                        end
                        err_q   <= bus_err;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    // The stalled instruction still presents its request here; ignore it
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall = ((state_q == IDLE) && (mem_re || mem_we))
                 || (state_q == REQ) || (state_q == WAIT);

    assign bus_req    = req_q;
    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign bus_wstrb  = wstrb_q;
    assign dm_data    = rdata_q;
    assign access_err = err_q;

endmodule
